// File: rtl/x7seg_scan_ctrl.sv
// x7seg_scan_ctrl: 4-digit seven-segment scan controller.
// It scans the digits with a blanking gap in every slot and decodes hex to segments.
// Leading zeros can be suppressed, and new values are double-buffered so they change only at frame boundaries.
module x7seg_scan_ctrl #(
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter logic [15:0] INIT_VAL     = 16'h1234
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        zsup_in,
  output logic        busy,
  output logic        frame_done,
  output logic [3:0]  an,
  output logic [6:0]  a_to_g,
  output logic        dp
);

  localparam int unsigned CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned SHOW_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(SHOW_CYCLES);

  localparam logic [0:0] ST_SHOW  = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        zsup;
  } disp_t;

  logic [0:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_dig, w_dig_nxt;
  logic             w_commit;
  logic             w_frame_nxt;

  disp_t            r_disp, r_stage;
  logic             r_busy;
  logic             r_frame_done;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic [3:0]       w_nib;
  logic             w_supp;
  logic             w_vis;

  // Active-low hex-to-segment patterns, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // Scan state register: phase, slot counter and digit index.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_SHOW;
      r_cnt   <= '0;
      r_dig   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dig   <= w_dig_nxt;
    end
  end

  // Next scan position. At the end of a slot the scan moves to the next digit, and after digit 3 it reaches the frame commit point.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_dig_nxt   = r_dig;
    w_commit    = 1'b0;
    case (r_state)
      ST_SHOW: begin
        if (w_cnt_nxt >= CNT_BLANK) w_state_nxt = ST_BLANK;
      end
      default: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
          w_dig_nxt   = r_dig + 2'd1;
          w_commit    = (r_dig == 2'd3);
        end
      end
    endcase
    w_frame_nxt = (w_dig_nxt == 2'd3) && (w_cnt_nxt == CNT_LAST);
  end

  // Staging handshake. The commit takes the old staged value, and a coincident load re-arms busy.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_disp.data  <= INIT_VAL;
      r_disp.dp    <= 4'h0;
      r_disp.zsup  <= 1'b0;
      r_stage      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_nxt;
      if (w_commit && r_busy) r_disp <= r_stage;
      if (load) begin
        r_stage.data <= data_in;
        r_stage.dp   <= dp_in;
        r_stage.zsup <= zsup_in;
        r_busy       <= 1'b1;
      end else if (w_commit) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Select the active nibble and decide whether the digit is lit.
  always_comb begin
    w_nib  = 4'(r_disp.data >> {r_dig, 2'b00});
    w_supp = 1'b0;
    case (r_dig)
      2'd3:    w_supp = (r_disp.data[15:12] == 4'h0);
      2'd2:    w_supp = (r_disp.data[15:8]  == 8'h00);
      2'd1:    w_supp = (r_disp.data[15:4]  == 12'h000);
      default: w_supp = 1'b0;
    endcase
    w_supp = w_supp && r_disp.zsup;
    w_vis  = en && (r_state == ST_SHOW) && !w_supp;
  end

  // Registered display drive, one clock behind the scan state.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (w_vis) begin
      r_an  <= ~(4'b0001 << r_dig);
      r_seg <= hex7(w_nib);
      r_dp  <= ~r_disp.dp[r_dig];
    end else begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign an         = r_an;
  assign a_to_g     = r_seg;
  assign dp         = r_dp;

endmodule

// File: tb/tb_x7seg_scan_ctrl.sv
// Bench for x7seg_scan_ctrl with SLOT_CYCLES=8 and BLANK_CYCLES=2, which gives a 32-clock frame.
// Expected values come from a frame-position model built from the display rules.
module tb_x7seg_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        zsup_in = 1'b0;
  logic        busy, frame_done, dp;
  logic [3:0]  an;
  logic [6:0]  a_to_g;

  x7seg_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .INIT_VAL(16'h1234)) dut (
    .clk(clk), .clr_n(clr_n), .en(en), .load(load), .data_in(data_in),
    .dp_in(dp_in), .zsup_in(zsup_in), .busy(busy), .frame_done(frame_done),
    .an(an), .a_to_g(a_to_g), .dp(dp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0]  seg_tab [16];
  logic [15:0] m_disp, m_sdata;
  logic [3:0]  m_dp, m_sdp;
  logic        m_zsup, m_szsup, m_busy;
  int          tick;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h tick=%0d", tag, obs, exp, tick);
    end
  endtask

  task automatic model_reset();
    m_disp = 16'h1234; m_dp = 4'h0; m_zsup = 1'b0;
    m_sdata = 16'h0; m_sdp = 4'h0; m_szsup = 1'b0;
    m_busy = 1'b0; tick = 0;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"},   16'(an),         16'hF);
    check({tag, "_seg"},  16'(a_to_g),     16'h7F);
    check({tag, "_dp"},   16'(dp),         16'h1);
    check({tag, "_busy"}, 16'(busy),       16'h0);
    check({tag, "_fd"},   16'(frame_done), 16'h0);
  endtask

  // One clock. The display expected after this edge comes from the frame position and display value before the edge.
  task automatic step();
    int pos, k, c;
    bit lit;
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp; logic e_fd;
    pos = tick % FRAME;
    k   = pos / SLOT;
    c   = pos % SLOT;
    lit = en && (c < SLOT - BLANK);
    if (k != 0 && m_zsup && (int'(m_disp) < (1 << (4 * k)))) lit = 0;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (lit) begin
      e_an  = 4'hF & ~(4'(1) << k);
      e_seg = seg_tab[(int'(m_disp) >> (4 * k)) & 15];
      e_dp  = ~m_dp[k];
    end
    if (pos == FRAME - 1 && m_busy) begin
      m_disp = m_sdata; m_dp = m_sdp; m_zsup = m_szsup;
    end
    if (load) begin
      m_sdata = data_in; m_sdp = dp_in; m_szsup = zsup_in; m_busy = 1'b1;
    end else if (pos == FRAME - 1) begin
      m_busy = 1'b0;
    end
    tick++;
    e_fd = ((tick % FRAME) == FRAME - 1);
    @(posedge clk); #1;
    check("an",         16'(an),         16'(e_an));
    check("a_to_g",     16'(a_to_g),     16'(e_seg));
    check("dp",         16'(dp),         16'(e_dp));
    check("busy",       16'(busy),       16'(m_busy));
    check("frame_done", 16'(frame_done), 16'(e_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int p);
    while ((tick % FRAME) != p) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic z);
    data_in = d; dp_in = p; zsup_in = z; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    model_reset();

    #23;
    check_off("reset");
    @(negedge clk);
    clr_n = 1'b1;

    // The first slot shows "4" on digit 0.
    step();
    check("first_an",  16'(an),     16'hE);
    check("first_seg", 16'(a_to_g), 16'(7'b1001100));
    run(2 * FRAME);

    // Load 00A5 with zero suppression in the middle of a frame.
    run_to(10);
    do_load(16'h00A5, 4'b0100, 1'b1);
    check("busy_after_load", 16'(busy), 16'h1);
    run_to(FRAME - 1);
    check("fd_at_commit", 16'(frame_done), 16'h1);
    run(FRAME + 4);
    check("busy_cleared", 16'(busy), 16'h0);

    // Two loads in one frame: only the second value appears.
    run_to(5);
    do_load(16'h1111, 4'h0, 1'b0);
    run(6);
    do_load(16'h2222, 4'h1, 1'b0);
    run(2 * FRAME);

    // Load on the frame_done cycle while 8888 is already staged.
    run_to(12);
    do_load(16'h8888, 4'h0, 1'b0);
    run_to(FRAME - 1);
    do_load(16'h9999, 4'h8, 1'b0);
    check("busy_rearmed", 16'(busy), 16'h1);
    run(FRAME);
    check("busy_second_commit", 16'(busy), 16'h0);
    run(FRAME);

    // en low for 20 clocks, entered mid-slot.
    run_to(3);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(FRAME);

    // Random loads, values and en toggles.
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      load    = ($urandom_range(0, 19) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 1) == 1) data_in = data_in >> (4 * $urandom_range(1, 4));
      dp_in   = 4'($urandom);
      zsup_in = 1'($urandom);
      step();
    end
    load = 1'b0; en = 1'b1;

    // Asynchronous reset in the middle of a slot with a load pending.
    run_to(40 % FRAME);
    do_load(16'hBEEF, 4'hF, 1'b0);
    run(2);
    #2 clr_n = 1'b0;
    #1 check_off("midreset");
    @(negedge clk);
    clr_n = 1'b1;
    model_reset();
    step();
    check("post_reset_an", 16'(an), 16'hE);
    run(2 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
